// File: rtl/fdd_pkg.sv
// Shared constants, FSM state type and LBA helper for the floppy track loader.
package fdd_pkg;

    localparam int SECTORS = 13;   // sectors per track
    localparam int TRACK_W = 6;    // track number width
    localparam int SEC_W   = 4;    // sector index width, 2^SEC_W >= SECTORS

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_DONE,
        RD_REQ,
        RD_DONE
    } fdd_state_e;

    // First SD sector of a track: t*13 built from shifts so no multiplier is inferred.
    function automatic logic [31:0] track_base(input logic [TRACK_W-1:0] t);
        logic [31:0] tz;
        tz = {{(32-TRACK_W){1'b0}}, t};
        return (tz << 3) + (tz << 2) + tz;
    endfunction

endpackage

// File: rtl/fdd_prio_enc.sv
// Lowest-set-bit encoder over the per-sector dirty mask.
module fdd_prio_enc
    import fdd_pkg::*;
(
    input  logic [SECTORS-1:0] mask,
    output logic [SEC_W-1:0]   idx,
    output logic               any
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = SECTORS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = SEC_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fdd_track_loader.sv
// One-track cache controller: writes back dirty sectors, then streams a new
// track in from SD sector by sector while stalling the CPU.
module fdd_track_loader
    import fdd_pkg::*;
(
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic [TRACK_W-1:0] track,
    input  logic               img_mounted,
    input  logic               img_size_nz,
    input  logic               img_readonly,
    input  logic               fd_write,
    input  logic [12:0]        fd_track_addr,
    input  logic               sd_ack,
    output logic [31:0]        sd_lba,
    output logic               sd_rd,
    output logic               sd_wr,
    output logic [SEC_W-1:0]   buf_sec,
    output logic               cpu_wait,
    output logic               track_valid,
    output logic [TRACK_W-1:0] cur_track
);

    localparam logic [SECTORS-1:0] SEC_ONE  = SECTORS'(1);
    localparam logic [SEC_W-1:0]   LAST_SEC = SEC_W'(SECTORS - 1);
    localparam logic [SEC_W-1:0]   NUM_SEC  = SEC_W'(SECTORS);

    fdd_state_e         state, state_nxt;
    logic               old_ack;
    logic               mounted, mounted_nxt;
    logic               ro, ro_nxt;
    logic               remount, remount_nxt;
    logic [SECTORS-1:0] dirty, dirty_nxt, dirty_w;
    logic [SEC_W-1:0]   buf_sec_nxt;
    logic [TRACK_W-1:0] cur_track_nxt;
    logic [31:0]        sd_lba_nxt;
    logic               sd_rd_nxt, sd_wr_nxt, cpu_wait_nxt, track_valid_nxt;

    logic               ack_rise, ack_fall;
    logic               trigger, remount_eff;
    logic [SEC_W-1:0]   wr_sec;
    logic               wr_hit;
    logic [SEC_W-1:0]   pe_idx;
    logic               pe_any;
    logic               unused_addr_bits;

    assign ack_rise = ~old_ack & sd_ack;
    assign ack_fall = old_ack & ~sd_ack;

    // Byte offset within the sector is irrelevant for dirty tracking.
    assign wr_sec           = fd_track_addr[12:9];
    assign unused_addr_bits = ^fd_track_addr[8:0];

    // Drive writes only count while idle on a valid, writable track; the CPU
    // is stalled otherwise. A write in the trigger cycle is folded in first.
    assign wr_hit  = (state == IDLE) && fd_write && track_valid && !ro && (wr_sec < NUM_SEC);
    assign dirty_w = wr_hit ? (dirty | (SEC_ONE << wr_sec)) : dirty;

    assign trigger     = mounted && (remount || (track != cur_track) || !track_valid);
    // A mount arriving on the same edge as an ack_fall must also abort.
    assign remount_eff = remount || img_mounted;

    fdd_prio_enc u_prio (
        .mask (dirty_w),
        .idx  (pe_idx),
        .any  (pe_any)
    );

    // Next-state, handshake and bookkeeping logic.
    always_comb begin
        state_nxt       = state;
        mounted_nxt     = mounted;
        ro_nxt          = ro;
        remount_nxt     = remount;
        dirty_nxt       = dirty_w;
        buf_sec_nxt     = buf_sec;
        cur_track_nxt   = cur_track;
        sd_rd_nxt       = sd_rd;
        sd_wr_nxt       = sd_wr;
        cpu_wait_nxt    = cpu_wait;
        track_valid_nxt = track_valid;

        case (state)
            IDLE: begin
                cpu_wait_nxt = trigger;
                if (trigger) begin
                    if (pe_any && track_valid) begin
                        // Old track still owns the buffer: flush it first.
                        buf_sec_nxt = pe_idx;
                        sd_wr_nxt   = 1'b1;
                        state_nxt   = WB_REQ;
                    end else begin
                        dirty_nxt     = '0;
                        remount_nxt   = 1'b0;
                        cur_track_nxt = track;
                        buf_sec_nxt   = '0;
                        sd_rd_nxt     = 1'b1;
                        state_nxt     = RD_REQ;
                    end
                end
            end
            WB_REQ: begin
                if (ack_rise) begin
                    sd_wr_nxt = 1'b0;
                    dirty_nxt = dirty & ~(SEC_ONE << buf_sec);
                    state_nxt = WB_DONE;
                end
            end
            WB_DONE: begin
                if (ack_fall) begin
                    if (remount_eff) begin
                        // New image: stale sectors must never reach it.
                        state_nxt = IDLE;
                    end else if (pe_any) begin
                        buf_sec_nxt = pe_idx;
                        sd_wr_nxt   = 1'b1;
                        state_nxt   = WB_REQ;
                    end else begin
                        remount_nxt   = 1'b0;
                        cur_track_nxt = track;
                        buf_sec_nxt   = '0;
                        sd_rd_nxt     = 1'b1;
                        state_nxt     = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (ack_rise) begin
                    sd_rd_nxt = 1'b0;
                    state_nxt = RD_DONE;
                end
            end
            RD_DONE: begin
                if (ack_fall) begin
                    if (remount_eff) begin
                        state_nxt = IDLE;
                    end else if (buf_sec == LAST_SEC) begin
                        track_valid_nxt = 1'b1;
                        cpu_wait_nxt    = 1'b0;
                        state_nxt       = IDLE;
                    end else begin
                        buf_sec_nxt = buf_sec + SEC_W'(1);
                        sd_rd_nxt   = 1'b1;
                        state_nxt   = RD_REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Mount overrides everything else on the same edge.
        if (img_mounted) begin
            mounted_nxt     = img_size_nz;
            ro_nxt          = img_readonly;
            remount_nxt     = 1'b1;
            track_valid_nxt = 1'b0;
        end

        // LBA follows the next track/sector so it is aligned with the request.
        sd_lba_nxt = track_base(cur_track_nxt) + {{(32-SEC_W){1'b0}}, buf_sec_nxt};
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            old_ack     <= 1'b0;
            mounted     <= 1'b0;
            ro          <= 1'b0;
            remount     <= 1'b0;
            dirty       <= '0;
            buf_sec     <= '0;
            cur_track   <= '0;
            sd_lba      <= '0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            cpu_wait    <= 1'b0;
            track_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            old_ack     <= sd_ack;
            mounted     <= mounted_nxt;
            ro          <= ro_nxt;
            remount     <= remount_nxt;
            dirty       <= dirty_nxt;
            buf_sec     <= buf_sec_nxt;
            cur_track   <= cur_track_nxt;
            sd_lba      <= sd_lba_nxt;
            sd_rd       <= sd_rd_nxt;
            sd_wr       <= sd_wr_nxt;
            cpu_wait    <= cpu_wait_nxt;
            track_valid <= track_valid_nxt;
        end
    end

endmodule

// File: tb/tb_fdd_track_loader.sv
// Directed + randomized bench for fdd_track_loader with an SD responder and
// a transfer-list reference model.
module tb_fdd_track_loader;
    import fdd_pkg::*;

    logic               clk_sys = 1'b0;
    logic               reset_n = 1'b1;
    logic [TRACK_W-1:0] track = '0;
    logic               img_mounted = 1'b0;
    logic               img_size_nz = 1'b0;
    logic               img_readonly = 1'b0;
    logic               fd_write = 1'b0;
    logic [12:0]        fd_track_addr = '0;
    logic               sd_ack = 1'b0;
    logic [31:0]        sd_lba;
    logic               sd_rd, sd_wr;
    logic [SEC_W-1:0]   buf_sec;
    logic               cpu_wait, track_valid;
    logic [TRACK_W-1:0] cur_track;

    fdd_track_loader dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .track         (track),
        .img_mounted   (img_mounted),
        .img_size_nz   (img_size_nz),
        .img_readonly  (img_readonly),
        .fd_write      (fd_write),
        .fd_track_addr (fd_track_addr),
        .sd_ack        (sd_ack),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .buf_sec       (buf_sec),
        .cpu_wait      (cpu_wait),
        .track_valid   (track_valid),
        .cur_track     (cur_track)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;

    // Reference model: what the buffer holds and which sectors were modified.
    int        m_cur = 0;
    bit        m_valid = 0;
    bit        m_ro = 0;
    bit [15:0] m_dirty = '0;

    typedef struct {
        bit wr;
        int sec;
        int lba;
    } xfer_t;
    xfer_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    // Expected SD traffic for a reload: dirty sectors of the held track in
    // ascending order, then all sectors of the new track.
    task automatic plan_load(input int t);
        q.delete();
        if (m_valid)
            for (int s = 0; s < SECTORS; s++)
                if (m_dirty[s]) q.push_back('{1'b1, s, m_cur * SECTORS + s});
        for (int s = 0; s < SECTORS; s++)
            q.push_back('{1'b0, s, t * SECTORS + s});
    endtask

    task automatic do_mount(input bit nz, input bit ro);
        img_mounted = 1'b1; img_size_nz = nz; img_readonly = ro;
        tick();
        img_mounted = 1'b0;
        m_ro = ro; m_valid = 0;
    endtask

    task automatic do_write(input logic [12:0] a, input bit move, input int t);
        logic [3:0] s;
        s = a[12:9];
        fd_track_addr = a; fd_write = 1'b1;
        if (m_valid && !m_ro && s < 4'(SECTORS)) m_dirty[s] = 1'b1;
        if (move) begin
            plan_load(t);
            track = TRACK_W'(t);
        end
        tick();
        fd_write = 1'b0;
    endtask

    task automatic move_track(input int t);
        plan_load(t);
        track = TRACK_W'(t);
        tick();
    endtask

    task automatic quiet(input int n);
        bit seen;
        seen = 0;
        repeat (n) begin
            tick();
            if (sd_rd || sd_wr) seen = 1;
        end
        chk("no_spurious_req", 32'(seen), 0);
    endtask

    // SD side: 4-cycle request->ack latency, ack held ack_len cycles.
    // inj selects the transfer during whose ack an img_mounted pulse is sent.
    task automatic serve(input int ack_len, input int inj);
        for (int i = 0; i < q.size(); i++) begin
            int n;
            n = 0;
            while (!(sd_rd || sd_wr) && n < 100) begin tick(); n++; end
            chk("req_seen", 32'(sd_rd | sd_wr), 1);
            chk("rd_wr_exclusive", 32'(sd_rd & sd_wr), 0);
            if (q[i].wr) chk("wr_req", 32'(sd_wr), 1);
            else         chk("rd_req", 32'(sd_rd), 1);
            chk("sd_lba", sd_lba, q[i].lba);
            chk("buf_sec", 32'(buf_sec), q[i].sec);
            chk("cpu_wait_busy", 32'(cpu_wait), 1);
            repeat (4) tick();
            chk("req_held", 32'(sd_rd | sd_wr), 1);
            sd_ack = 1'b1;
            for (int c = 0; c < ack_len; c++) begin
                tick();
                if (c == 0) chk("req_drop_on_ack", 32'(sd_rd | sd_wr), 0);
                if (i == inj && c == 1) img_mounted = 1'b1;
                if (i == inj && c == 2) begin img_mounted = 1'b0; m_valid = 0; end
            end
            sd_ack = 1'b0;
            tick();
        end
    endtask

    task automatic finish_load(input int t);
        int n;
        n = 0;
        while (cpu_wait && n < 50) begin tick(); n++; end
        chk("cpu_wait_release", 32'(cpu_wait), 0);
        chk("track_valid_set", 32'(track_valid), 1);
        chk("cur_track", 32'(cur_track), t);
        m_cur = t; m_valid = 1; m_dirty = '0;
        quiet(5);
    endtask

    initial begin
        int t, nw, inj, n;

        // Reset values while reset is held.
        #1 reset_n = 1'b0;
        #1;
        chk("rst_sd_lba", sd_lba, 0);
        chk("rst_sd_rd", 32'(sd_rd), 0);
        chk("rst_sd_wr", 32'(sd_wr), 0);
        chk("rst_buf_sec", 32'(buf_sec), 0);
        chk("rst_cpu_wait", 32'(cpu_wait), 0);
        chk("rst_track_valid", 32'(track_valid), 0);
        chk("rst_cur_track", 32'(cur_track), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        quiet(5);

        // First mount at track 0 with long acks.
        track = '0;
        do_mount(1, 0);
        plan_load(0);
        serve(512, -1);
        finish_load(0);

        // Plain track change.
        move_track(5);
        serve(6, -1);
        finish_load(5);

        // Two dirty sectors (3 and 12) flushed before loading track 6.
        do_write(13'h0600, 0, 0);
        do_write(13'h1800, 0, 0);
        move_track(6);
        serve(6, -1);
        finish_load(6);

        // Randomized writes and track moves, including track 63 and writes
        // landing on the trigger edge.
        for (int it = 0; it < 6; it++) begin
            t = (it == 0) ? 63 : int'($urandom_range(0, 63));
            if (t == m_cur) t = (t + 1) % 64;
            nw = int'($urandom_range(0, 4));
            for (int w = 0; w < nw; w++) do_write(13'($urandom), 0, 0);
            if ($urandom_range(0, 1) == 1) do_write(13'($urandom_range(0, 6655)), 1, t);
            else move_track(t);
            serve(int'($urandom_range(4, 16)), -1);
            finish_load(t);
        end

        // Read-only image: writes never produce write-back.
        do_mount(1, 1);
        plan_load(m_cur);
        serve(5, -1);
        finish_load(m_cur);
        do_write(13'h0200, 0, 0);
        do_write(13'($urandom), 0, 0);
        move_track((m_cur + 7) % 64);
        serve(5, -1);
        finish_load((m_cur + 7) % 64);

        // Writable again; dirty write-back, then a mount during read of sector 4.
        do_mount(1, 0);
        plan_load(m_cur);
        serve(5, -1);
        finish_load(m_cur);
        do_write(13'h0400, 0, 0);
        do_write(13'h0a00, 0, 0);
        t = (m_cur + 11) % 64;
        plan_load(t);
        repeat (8) void'(q.pop_back());
        inj = q.size() - 1;
        for (int s = 0; s < SECTORS; s++) q.push_back('{1'b0, s, t * SECTORS + s});
        track = TRACK_W'(t);
        tick();
        serve(8, inj);
        finish_load(t);

        // Zero-size image: nothing happens, CPU is not stalled.
        do_mount(0, 0);
        track = TRACK_W'((m_cur + 1) % 64);
        quiet(30);
        chk("nz0_cpu_wait", 32'(cpu_wait), 0);
        chk("nz0_track_valid", 32'(track_valid), 0);

        // Reset while a read is outstanding.
        track = TRACK_W'(9);
        do_mount(1, 0);
        n = 0;
        while (!sd_rd && n < 100) begin tick(); n++; end
        chk("pre_rst_sd_rd", 32'(sd_rd), 1);
        chk("pre_rst_sd_lba", sd_lba, 117);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_sd_rd", 32'(sd_rd), 0);
        chk("mid_rst_cpu_wait", 32'(cpu_wait), 0);
        chk("mid_rst_track_valid", 32'(track_valid), 0);
        chk("mid_rst_sd_lba", sd_lba, 0);
        tick();
        reset_n = 1'b1;
        m_cur = 0; m_valid = 0; m_ro = 0; m_dirty = '0;
        track = TRACK_W'(10);
        quiet(40);
        chk("post_rst_cpu_wait", 32'(cpu_wait), 0);

        // Recovery: a fresh mount loads normally.
        track = TRACK_W'(20);
        do_mount(1, 0);
        plan_load(20);
        serve(6, -1);
        finish_load(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fdd_track_loader.md
Name: fdd_track_loader

Overview:
- Floppy track-cache controller sitting between the Disk II emulation and the SD block-device handshake.
- Keeps exactly one 13-sector track (13 x 512 B = 6656 B) in the downstream one-track buffer RAM.
- On a track change or image mount it writes dirty sectors back to SD, then reads the new track sector by sector, stalling the CPU while busy.
- Generates the sector index that forms the buffer RAM high address bits during SD transfers.

Parameters:
- SECTORS, 13: sectors per track; LBA base = track*SECTORS.
- TRACK_W, 6: width of the track number.
- SEC_W, 4: width of the sector index; must satisfy 2^SEC_W >= SECTORS.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- track  in  TRACK_W  track requested by the drive head.
- img_mounted  in  1  one-cycle pulse: a new image was mounted.
- img_size_nz  in  1  the mounted image size is non-zero.
- img_readonly  in  1  the image is write-protected; sampled on img_mounted.
- fd_write  in  1  one-cycle pulse: the drive wrote a byte into the buffer.
- fd_track_addr  in  13  buffer byte address of that write; bits [12:9] give the sector.
- sd_ack  in  1  SD transfer acknowledge; high for the duration of one sector transfer.
- sd_lba  out  32  SD sector address.
- sd_rd  out  1  SD read request.
- sd_wr  out  1  SD write request.
- buf_sec  out  SEC_W  sector index; the buffer RAM address is {buf_sec, sd_buff_addr}.
- cpu_wait  out  1  stall the CPU.
- track_valid  out  1  the buffer holds cur_track of the mounted image.
- cur_track  out  TRACK_W  track currently held in the buffer.

Behaviour:
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, buf_sec=0, cpu_wait=0, track_valid=0, cur_track=0. Internal: dirty mask = 0, mounted = 0, ro = 0, state = IDLE, old_ack = 0.
- Ack edges: old_ack is registered every cycle. ack_rise = ~old_ack & sd_ack; ack_fall = old_ack & ~sd_ack.
- Mount handling: img_mounted sets mounted = img_size_nz and ro = img_readonly. It also sets the pending flag remount and clears track_valid.
- Dirty tracking: in IDLE, when track_valid and ~ro, fd_write sets dirty[fd_track_addr[12:9]]. Writes with sector index >= SECTORS are ignored. fd_write outside IDLE is ignored, because the CPU is stalled.
- LBA arithmetic: base = track*13, computed as (t<<3)+(t<<2)+t and zero-extended to 32 bits. sd_lba = base + buf_sec, registered.

State machine:
- IDLE:
  - Trigger condition: mounted && (remount || track != cur_track || ~track_valid).
  - If the trigger holds and dirty != 0 and the old image is still valid: go to WB_REQ. buf_sec = lowest set dirty bit; base uses cur_track.
  - Otherwise, if the trigger holds: clear dirty and remount, latch cur_track <= track, set buf_sec = 0, go to RD_REQ.
  - cpu_wait rises in the cycle after the trigger.
- WB_REQ: sd_wr=1. On ack_rise: sd_wr=0, clear dirty[buf_sec], go to WB_DONE.
- WB_DONE: on ack_fall, pick the next set dirty bit and return to WB_REQ. If none remain, latch the new track, set buf_sec = 0, go to RD_REQ.
- RD_REQ: sd_rd=1. On ack_rise: sd_rd=0, go to RD_DONE.
- RD_DONE: on ack_fall:
  - If buf_sec == SECTORS-1: track_valid=1, cpu_wait=0, go to IDLE.
  - Otherwise: buf_sec += 1, go to RD_REQ.
- sd_rd and sd_wr are never both high. Each request stays asserted until ack_rise.

Boundary conditions:
- img_mounted mid-transfer: the current sector handshake completes. Write-back is abandoned, since the new image must not receive stale data. After the current ack_fall the block returns to IDLE and then reloads.
- Track change during a read: the load finishes, then IDLE sees track != cur_track and reloads. No request is dropped.
- img_size_nz=0 on mount: mounted=0, the block stays IDLE, cpu_wait=0.
- fd_write coinciding with the IDLE trigger: the dirty bit is set first, so it is included in write-back.
- reset_n low mid-transfer: immediate return to reset values; no request is held.
- track wraps: a value of 63 is valid (LBA 819..831).

Decomposition:
- Shared package fdd_pkg: SECTORS, TRACK_W, SEC_W, state enum {IDLE, WB_REQ, WB_DONE, RD_REQ, RD_DONE}, and the helper function track_base(t).
- One sub-module, fdd_prio_enc: a lowest-set-bit encoder over the 13-bit dirty mask, with outputs idx and any.

Test Plan:
- Mount with img_size_nz=1 and track=0; bench acks with 4-cycle rd->ack latency and 512-cycle ack -> 13 reads at sd_lba 0..12, buf_sec 0..12; then cpu_wait=0, track_valid=1.
- After load, track=5 -> sd_lba 65..77; cur_track=5.
- Track 5 loaded, fd_write at addr 0x0600 and 0x1800, then track=6 -> sd_wr at lba 68, then lba 77; then reads at 78..90; dirty=0.
- img_readonly=1 mount, fd_write, then track change -> no sd_wr; reads only.
- img_mounted pulse during the read of sector 4 -> sector 4 completes; reload restarts at buf_sec 0; no write-back issued.
- reset_n low while sd_rd=1 -> next sample shows sd_rd=0, cpu_wait=0, track_valid=0; after release, no request until a mount.
